// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: sequences one L1 I-cache line refill from miss to cache write, tolerating mid-refill flushes.
module icache_refill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] missAddr_i,
  input  logic              flush_i,
  output logic              memReqValid_o,
  input  logic              memReqReady_i,
  output logic [ADDR_W-1:0] memReqAddr_o,
  input  logic              memRespValid_i,
  input  logic [BEAT_W-1:0] memRespData_i,
  output logic              wrEnable_o,
  output logic [ADDR_W-1:0] wrAddr_o,
  output logic [LINE_W-1:0] instBlock_o,
  output logic              busy_o
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, WRITE, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d, blk_q, blk_d;
  logic last_beat;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      line_q    <= '0;
      blk_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      blk_q     <= blk_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    line_d    = line_q;
    blk_d     = blk_q;
    last_beat = memRespValid_i && cnt_q == CW'(BEATS - 1);
    if ((state_q == FILL || state_q == DRAIN) && memRespValid_i) cnt_d = cnt_q + 1'b1;
    if (state_q == FILL && memRespValid_i) line_d[cnt_q*BEAT_W +: BEAT_W] = memRespData_i;
    case (state_q)
      IDLE: if (miss_i && !flush_i) begin
        state_d = REQ;
        addr_d  = missAddr_i & ~ADDR_W'(LINE_W / 8 - 1);
      end
      REQ: begin
        cnt_d = '0;
        if (memReqReady_i) state_d = flush_i ? DRAIN : FILL;
        else if (flush_i) state_d = IDLE;
      end
      // A complete line is architecturally valid, so it wins over a simultaneous flush.
      FILL: if (last_beat) begin
        state_d   = WRITE;
        wr_addr_d = addr_q;
        blk_d     = line_d;
      end else if (flush_i) state_d = DRAIN;
      DRAIN: if (last_beat) state_d = IDLE;
      WRITE: state_d = HOLD;
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    memReqValid_o = state_q == REQ;
    memReqAddr_o  = addr_q;
    wrEnable_o    = state_q == WRITE;
    wrAddr_o      = wr_addr_q;
    instBlock_o   = blk_q;
    busy_o        = state_q != IDLE;
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed and randomized refills checked against a transaction-level line model.
module tb_icache_refill_ctrl;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;
  logic clk = 0, reset = 1, miss = 0, flush = 0, ready = 0, rv = 0;
  logic [AW-1:0] maddr = '0;
  logic [BW-1:0] rdata = '0;
  logic req_valid, wr_en, busy;
  logic [AW-1:0] req_addr, wr_addr;
  logic [LW-1:0] blk;
  int total = 0, bad = 0;
  logic [AW-1:0] last_wa = '0;
  logic [LW-1:0] last_blk = '0;
  icache_refill_ctrl #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW)) dut (
    .clk(clk), .reset(reset), .miss_i(miss), .missAddr_i(maddr), .flush_i(flush),
    .memReqValid_o(req_valid), .memReqReady_i(ready), .memReqAddr_o(req_addr),
    .memRespValid_i(rv), .memRespData_i(rdata),
    .wrEnable_o(wr_en), .wrAddr_o(wr_addr), .instBlock_o(blk), .busy_o(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a - a % AW'(LW / 8);
  endfunction
  // fl: -3 flush with handshake, -2 flush in REQ, -1 none, 0..NB-1 flush after fl beats, NB flush with WRITE
  task automatic do_refill(input logic [AW-1:0] a, input int stall, input int gapmax, input int fl,
                           input bit hm, input bit pat);
    logic [AW-1:0] ra;
    logic [LW-1:0] exp;
    int k, n, guard;
    bit fd;
    ra = align(a);
    exp = '0;
    k = 0;
    n = 0;
    miss = 1;
    maddr = a;
    flush = 0;
    ready = 0;
    rv = 0;
    cyc();
    n++;
    chk("req_valid", req_valid, 1);
    chk("req_addr", req_addr, ra);
    chk("req_busy", busy, 1);
    miss = 1'($urandom_range(0, 1));
    maddr = $urandom;
    for (int i = 0; i < stall; i++) begin
      cyc();
      n++;
      chk("stall_valid", req_valid, 1);
      chk("stall_addr", req_addr, ra);
      maddr = $urandom;
    end
    if (fl == -2) begin
      flush = 1;
      miss = 0;
      cyc();
      flush = 0;
      chk("withdraw_valid", req_valid, 0);
      chk("withdraw_busy", busy, 0);
      return;
    end
    ready = 1;
    flush = fl == -3;
    fd = flush;
    cyc();
    n++;
    ready = 0;
    flush = 0;
    guard = 0;
    while (k < NB && guard < 200) begin
      chk("fill_busy", busy, 1);
      chk("fill_wr", wr_en, 0);
      chk("fill_noreq", req_valid, 0);
      rv = $urandom_range(0, gapmax) == 0;
      rdata = pat ? {16{4'(k + 1)}} : {$urandom, $urandom};
      if (fd) flush = 1'($urandom_range(0, 1));
      else if (fl == k) begin
        flush = 1;
        if (k == NB - 1) rv = 0;
      end
      fd = fd || flush;
      cyc();
      n++;
      guard++;
      if (rv) begin
        exp = exp | (LW'(rdata) << (BW * k));
        k++;
      end
    end
    rv = 0;
    flush = 0;
    if (guard >= 200) chk("beat_budget", k, NB);
    if (fd) begin
      miss = 0;
      chk("drain_idle", busy, 0);
      chk("drain_nowr", wr_en, 0);
      chk("drain_keep_addr", wr_addr, last_wa);
      chk("drain_keep_blk", blk, last_blk);
    end else begin
      chk("wr_en", wr_en, 1);
      chk("wr_addr", wr_addr, ra);
      chk("wr_blk", blk, exp);
      if (stall == 0 && gapmax == 0) chk("latency", n, 6);
      last_wa = ra;
      last_blk = exp;
      flush = fl == NB;
      miss = hm;
      cyc();
      flush = 0;
      chk("hold_wr", wr_en, 0);
      chk("hold_busy", busy, 1);
      chk("hold_noreq", req_valid, 0);
      cyc();
      chk("idle_busy", busy, 0);
      chk("idle_noreq", req_valid, 0);
      chk("idle_keep_addr", wr_addr, ra);
      chk("idle_keep_blk", blk, exp);
    end
  endtask
  initial begin
    int fl;
    cyc();
    cyc();
    chk("rst_valid", req_valid, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reqaddr", req_addr, 0);
    chk("rst_wraddr", wr_addr, 0);
    chk("rst_blk", blk, 0);
    reset = 0;
    cyc();
    do_refill(32'h0000_1234, 0, 0, -1, 0, 1);
    chk("basic_reqaddr", req_addr, 32'h0000_1220);
    chk("basic_wraddr", wr_addr, 32'h0000_1220);
    chk("basic_blk", blk, 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    do_refill(32'hABCD_0F3C, 5, 1, -1, 0, 0);
    do_refill(32'h8000_0100, 0, 1, 2, 0, 0);
    do_refill(32'h0000_0040, 0, 0, -1, 0, 1);
    do_refill(32'h0000_2000, 2, 0, -2, 0, 0);
    do_refill(32'h0000_3000, 1, 1, -3, 0, 0);
    do_refill(32'h0000_5008, 0, 0, NB, 1, 0);
    do_refill(32'h0000_6010, 0, 0, -1, 0, 0);
    miss = 1;
    maddr = 32'h0000_7777;
    cyc();
    miss = 0;
    ready = 1;
    cyc();
    ready = 0;
    rv = 1;
    rdata = {$urandom, $urandom};
    cyc();
    rv = 0;
    reset = 1;
    cyc();
    reset = 0;
    chk("mrst_valid", req_valid, 0);
    chk("mrst_wr", wr_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_reqaddr", req_addr, 0);
    chk("mrst_wraddr", wr_addr, 0);
    chk("mrst_blk", blk, 0);
    cyc();
    chk("mrst_idle", busy, 0);
    chk("mrst_nowr", wr_en, 0);
    last_wa = '0;
    last_blk = '0;
    for (int i = 0; i < 40; i++) begin
      fl = $urandom_range(0, 8) - 3;
      if (fl > NB) fl = -1;
      do_refill($urandom, $urandom_range(0, 3), $urandom_range(0, 2), fl, 1'($urandom_range(0, 1)), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
